// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

   localparam int MAX_W = 64;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MAG   = 3'd1,
      ACCUM = 3'd2,
      FIX   = 3'd3,
      DONE  = 3'd4
   } state_t;

   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // Callers zero-extend into MAX_W and truncate the result back to their width.
   function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] v);
      return ~v + MAX_W'(1);
   endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Multiplier datapath: operand/magnitude registers, 2N-bit accumulator and one
// N-bit adder reused on every ACCUM cycle.
module seq_mult_dp import mult_pkg::*; #(
   parameter int N  = 4,
   parameter int CW = cnt_width(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            capture,
   input  logic            load,
   input  logic            step,
   input  logic            fix,
   input  logic [CW-1:0]   cnt,
   input  logic            is_signed,
   input  logic [N-1:0]    a,
   input  logic [N-1:0]    b,
   output logic [2*N-1:0]  p
);

   logic [N-1:0]   a_reg, b_reg;
   logic           sgn_reg, neg_reg;
   logic [2*N-1:0] acc;
   logic [N-1:0]   a_neg, b_neg, a_mag, b_mag, addend, sum;
   logic [2*N-1:0] acc_neg;
   logic           cout;

   assign a_neg   = N'(negate(MAX_W'(a_reg)));
   assign b_neg   = N'(negate(MAX_W'(b_reg)));
   assign acc_neg = (2*N)'(negate(MAX_W'(acc)));

   assign a_mag = (sgn_reg && a_reg[N-1]) ? a_neg : a_reg;
   assign b_mag = (sgn_reg && b_reg[N-1]) ? b_neg : b_reg;

   // After load, a_reg/b_reg hold magnitudes; b selects whether a is added.
   assign addend = b_reg[cnt] ? a_reg : '0;

   seq_mult_rca #(.W(N)) u_rca (
      .a    (acc[2*N-1:N]),
      .b    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg   <= '0;
         b_reg   <= '0;
         sgn_reg <= 1'b0;
         neg_reg <= 1'b0;
         acc     <= '0;
         p       <= '0;
      end else begin
         if (capture) begin
            a_reg   <= a;
            b_reg   <= b;
            sgn_reg <= is_signed;
         end
         if (load) begin
            a_reg   <= a_mag;
            b_reg   <= b_mag;
            neg_reg <= sgn_reg & (a_reg[N-1] ^ b_reg[N-1]);
            acc     <= '0;
         end
         if (step) acc <= {cout, sum, acc[N-1:1]};
         if (fix)  p   <= neg_reg ? acc_neg : acc;
      end
   end

endmodule

// File: rtl/seq_mult_rca.sv
// W-bit ripple-carry adder.
module seq_mult_rca #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[W];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier controller with valid/ready on both sides.
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   MAG   | convert latched operands to magnitudes, record result sign
//   ACCUM | N add/shift steps, one multiplier bit per cycle
//   FIX   | apply sign to accumulator, load P
//   DONE  | out_valid high, P held until out_ready
module seq_mult_ctrl import mult_pkg::*; #(
   parameter int N = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            is_signed,
   input  logic [N-1:0]    A,
   input  logic [N-1:0]    B,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*N-1:0]  P,
   output logic            busy
);

   localparam int            CW   = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N-1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          capture, load, step, fix;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   assign capture = in_ready && in_valid;
   assign load    = (state == MAG);
   assign step    = (state == ACCUM);
   assign fix     = (state == FIX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE:  if (in_valid) state <= MAG;
            MAG: begin
               cnt   <= '0;
               state <= ACCUM;
            end
            ACCUM: begin
               cnt <= cnt + CW'(1);
               if (cnt == LAST) state <= FIX;
            end
            FIX:   state <= DONE;
            DONE:  if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   seq_mult_dp #(.N(N), .CW(CW)) u_dp (
      .clk       (clk),
      .rst       (rst),
      .capture   (capture),
      .load      (load),
      .step      (step),
      .fix       (fix),
      .cnt       (cnt),
      .is_signed (is_signed),
      .a         (A),
      .b         (B),
      .p         (P)
   );

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl: directed cases, backpressure, reset
// abort, then every operand pair in both signed and unsigned modes.
module tb_seq_mult_ctrl;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic           is_signed = 1'b0;
   logic [N-1:0]   A = '0;
   logic [N-1:0]   B = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [2*N-1:0] P;
   logic           busy;

   int checks = 0;
   int errors = 0;
   int accepts = 0;
   int handshakes = 0;

   always #5 clk = ~clk;

   seq_mult_ctrl #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .is_signed (is_signed),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .P         (P),
      .busy      (busy)
   );

   always @(posedge clk) begin
      if (in_valid && in_ready)   accepts    <= accepts + 1;
      if (out_valid && out_ready) handshakes <= handshakes + 1;
   end

   function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic s);
      longint x, y;
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
      return (2*N)'(x * y);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction; operands are scrambled after the accept edge, and
   // in_valid is held high throughout the DONE stall and the release edge.
   task automatic do_txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         input int stall, input logic [2*N-1:0] exp);
      int k;
      A = a; B = b; is_signed = s; in_valid = 1'b1; out_ready = 1'b0;
      k = 0;
      while (!in_ready && k < 50) begin
         tick();
         k++;
      end
      check("in_ready_before_accept", in_ready, 1);
      tick();
      k = 0;
      while (!out_valid && k < 50) begin
         check("busy_in_flight", busy, 1);
         check("in_ready_in_flight", in_ready, 0);
         A = N'($urandom); B = N'($urandom); is_signed = 1'($urandom); in_valid = 1'($urandom);
         tick();
         k++;
      end
      check("latency", k, N + 2);
      check("product", P, exp);
      check("busy_done", busy, 1);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1; A = N'($urandom); B = N'($urandom);
         tick();
         check("stall_product", P, exp);
         check("stall_out_valid", out_valid, 1);
         check("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      tick();
      check("release_out_valid", out_valid, 0);
      check("release_in_ready", in_ready, 1);
      check("release_product_held", P, exp);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      check("reset_in_ready", in_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_p", P, 0);

      do_txn(4'd15, 4'd15, 1'b0, 0, 8'hE1);
      do_txn(4'b1101, 4'b0101, 1'b1, 2, 8'hF1);
      do_txn(4'b1000, 4'b1000, 1'b1, 0, 8'h40);
      do_txn(4'b1000, 4'b1000, 1'b0, 1, 8'h40);
      do_txn(4'd0, 4'hF, 1'b1, 0, 8'h00);
      do_txn(4'd15, 4'd15, 1'b0, 10, 8'hE1);

      // Abort during the second ACCUM cycle; P still holds 8'hE1 beforehand.
      A = 4'd9; B = 4'd6; is_signed = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("pre_abort_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("abort_in_ready", in_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_p", P, 0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < N + 4; i++) begin
         tick();
         check("no_out_valid_after_abort", out_valid, 0);
      end
      out_ready = 1'b0;
      do_txn(4'd7, 4'd3, 1'b0, 0, 8'h15);

      for (int s = 0; s < 2; s++)
         for (int a = 0; a < (1 << N); a++)
            for (int b = 0; b < (1 << N); b++)
               do_txn(N'(a), N'(b), 1'(s), int'($urandom_range(0, 3)),
                      ref_prod(N'(a), N'(b), 1'(s)));

      tick();
      check("one_handshake_per_accept", handshakes, accepts - 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
